sram_like_resp: RTL

- Responder (slave) end of the req/addr_ok/data_ok SRAM-like interface that the fetch and memory stages drive as initiators.
- Accepts up to DEPTH outstanding requests and issues each one to a synchronous RAM with fixed read latency MEM_LAT.
- Returns responses in order through a small response buffer.
- Serves as the CPU-side memory model and as the front half of the later AXI bridge; resp_stall injects response backpressure.

---
 rtl/sram_like_resp_pkg.sv | 27 ++
 rtl/sram_like_resp_fifo.sv | 69 ++++++
 rtl/sram_like_resp.sv | 115 +++++++++++
 3 files changed

// File: rtl/sram_like_resp_pkg.sv
// Shared types for the SRAM-like responder: access-size encodings and the
// response entry carried from the latency pipe through the response FIFO.
package sram_like_resp_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // One response: write flag plus 32-bit data.
  localparam int unsigned ENTRY_W = 33;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
  } resp_entry_t;

  // Writes always answer with zero data so nothing stale reaches the initiator.
  function automatic resp_entry_t make_entry(input logic wr, input logic [31:0] rdata);
    resp_entry_t e;
    e.wr   = wr;
    e.data = wr ? '0 : rdata;
    return e;
  endfunction

endpackage

// File: rtl/sram_like_resp_fifo.sv
// Response buffer: DEPTH x WIDTH synchronous FIFO with async reset.
// Empty/full come from the occupancy counter, pointers wrap naturally.
module sram_like_resp_fifo
  import sram_like_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full_o;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Outstanding-request accounting upstream must keep the buffer from filling past DEPTH.
  assert property (@(posedge clk) disable iff (reset) !(push_i && full_o));

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: accepts up to DEPTH outstanding req/addr_ok requests,
// issues them to a fixed-latency synchronous RAM and returns data_ok responses
// strictly in acceptance order through a small response FIFO.
module sram_like_resp
  import sram_like_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned RAM_AW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  input  logic              resp_stall,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MEM_LAT-1:0] pv_q, pv_d;
  logic [MEM_LAT-1:0] pwr_q, pwr_d;

  logic        hs;
  logic        tail_v;
  logic        bypass;
  logic        fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  resp_entry_t tail_e, head_e;
  logic        unused_bits;

  // Access size and the address bits outside the word index are carried only.
  assign unused_bits = ^{size, addr};

  // Accept while fewer than DEPTH requests sit in the pipe plus the FIFO.
  assign addr_ok   = req && (cnt_q < CNT_W'(DEPTH));
  assign hs        = req && addr_ok;

  assign ram_en    = hs;
  assign ram_we    = (hs && wr) ? wstrb : '0;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // The tail stage lines up with ram_rdata for its request.
  assign tail_v    = pv_q[MEM_LAT-1];
  assign tail_e    = make_entry(pwr_q[MEM_LAT-1], ram_rdata);

  // Bypass only when nothing older waits in the FIFO, preserving order.
  assign bypass    = tail_v && fifo_empty && !resp_stall;
  assign fifo_push = tail_v && !bypass;
  assign fifo_pop  = !fifo_empty && !resp_stall;
  assign data_ok   = bypass || fifo_pop;

  // Response data mux; zero whenever no response is presented.
  always_comb begin
    rdata = '0;
    if (fifo_pop)    rdata = head_e.data;
    else if (bypass) rdata = tail_e.data;
  end

  // Latency pipe shift (size cast drops the oldest stage) and outstanding count.
  always_comb begin
    pv_d  = MEM_LAT'({pv_q, hs});
    pwr_d = MEM_LAT'({pwr_q, hs && wr});
    cnt_d = cnt_q;
    if (hs && !data_ok)      cnt_d = cnt_q + CNT_W'(1);
    else if (!hs && data_ok) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pipe and count registers; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q  <= '0;
      pwr_q <= '0;
      cnt_q <= '0;
    end else begin
      pv_q  <= pv_d;
      pwr_q <= pwr_d;
      cnt_q <= cnt_d;
    end
  end

  sram_like_resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (tail_e),
    .pop_i       (fifo_pop),
    .head_o      (head_e),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assert property (@(posedge clk) disable iff (reset) cnt_q <= CNT_W'(DEPTH));
  assert property (@(posedge clk) disable iff (reset) fifo_cnt <= cnt_q);
  assert property (@(posedge clk) disable iff (reset) !(fifo_full && tail_v));

endmodule
